// File: rtl/mwpipe_skid.sv
// Memory-to-writeback two-entry skid buffer with a registered ready, so there is no combinational path from ready_W to ready_M.
// The optional stall counter is built only when MWPIPE_STALL_CNT_EN is defined; otherwise stall_cnt is tied to 0.

module mwpipe_skid_lane #(
   parameter int LANE_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              main_ld,
   input  logic              main_sel_skid,
   input  logic              skid_ld,
   input  logic [LANE_W-1:0] d,
   output logic [LANE_W-1:0] q
);
   logic [LANE_W-1:0] main_r, skid_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_r <= '0;
         skid_r <= '0;
      end else begin
         if (skid_ld) skid_r <= d;
         if (main_ld) main_r <= main_sel_skid ? skid_r : d;
      end
   end

   assign q = main_r;
endmodule

module mwpipe_skid #(
   parameter int SCALAR_W = 32,
   parameter int LANES    = 4,
   parameter int LANE_W   = 32,
   parameter int RADDR_W  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    valid_M,
   output logic                    ready_M,
   input  logic                    regw_M,
   input  logic                    regmem_M,
   input  logic [RADDR_W-1:0]      regScr_M,
   input  logic [SCALAR_W-1:0]     ALUrslt_M,
   input  logic [LANES*LANE_W-1:0] regVrslt_M,
   input  logic                    flush,
   output logic                    valid_W,
   input  logic                    ready_W,
   output logic                    regw_W,
   output logic                    regmem_W,
   output logic [RADDR_W-1:0]      regScr_W,
   output logic [SCALAR_W-1:0]     ALUrslt_W,
   output logic [LANES*LANE_W-1:0] regVrslt_W,
   output logic [15:0]             stall_cnt
);
   typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

   typedef struct packed {
      logic                regw;
      logic                regmem;
      logic [RADDR_W-1:0]  scr;
      logic [SCALAR_W-1:0] alu;
   } ctl_t;

   state_t state, state_n;
   logic   ready_q, valid_q;
   logic   main_ld, skid_ld, main_sel_skid;
   logic   in_xfer, out_xfer;
   ctl_t   ctl_in, ctl_main, ctl_skid;
   logic [LANES-1:0][LANE_W-1:0] vec_m, vec_w;

   assign in_xfer  = valid_M && ready_q;
   assign out_xfer = valid_q && ready_W;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_EMPTY;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         state   <= state_n;
         ready_q <= (state_n != S_TWO);
         valid_q <= (state_n != S_EMPTY);
      end
   end

   always_comb begin
      state_n       = state;
      main_ld       = 1'b0;
      skid_ld       = 1'b0;
      main_sel_skid = 1'b0;
      case (state)
         S_EMPTY: if (in_xfer) begin
            state_n = S_ONE;
            main_ld = 1'b1;
         end
         S_ONE: case ({in_xfer, out_xfer})
            2'b10: begin
               state_n = S_TWO;
               skid_ld = 1'b1;
            end
            2'b11:   main_ld = 1'b1;
            2'b01:   state_n = S_EMPTY;
            default: state_n = S_ONE;
         endcase
         S_TWO: if (out_xfer) begin
            state_n       = S_ONE;
            main_ld       = 1'b1;
            main_sel_skid = 1'b1;
         end
         default: state_n = S_EMPTY;
      endcase
      // Flush beats any handshake on the same edge; held payloads just go stale.
      if (flush) begin
         state_n       = S_EMPTY;
         main_ld       = 1'b0;
         skid_ld       = 1'b0;
         main_sel_skid = 1'b0;
      end
   end

   assign ctl_in = '{regw: regw_M, regmem: regmem_M, scr: regScr_M, alu: ALUrslt_M};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctl_main <= '0;
         ctl_skid <= '0;
      end else begin
         if (skid_ld) ctl_skid <= ctl_in;
         if (main_ld) ctl_main <= main_sel_skid ? ctl_skid : ctl_in;
      end
   end

   assign vec_m = regVrslt_M;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      mwpipe_skid_lane #(.LANE_W(LANE_W)) u_lane (
         .clk           (clk),
         .rst           (rst),
         .main_ld       (main_ld),
         .main_sel_skid (main_sel_skid),
         .skid_ld       (skid_ld),
         .d             (vec_m[g]),
         .q             (vec_w[g])
      );
   end

   assign ready_M    = ready_q;
   assign valid_W    = valid_q;
   // Bubbles must never look like a register write.
   assign regw_W     = ctl_main.regw & valid_q;
   assign regmem_W   = ctl_main.regmem;
   assign regScr_W   = ctl_main.scr;
   assign ALUrslt_W  = ctl_main.alu;
   assign regVrslt_W = vec_w;

`ifdef MWPIPE_STALL_CNT_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_q <= '0;
      else if (flush)
         stall_q <= '0;
      else if (valid_q && !ready_W && stall_q != 16'hFFFF)
         stall_q <= stall_q + 16'd1;
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = '0;
`endif
endmodule

// File: doc/mwpipe_skid.md
MWPIPE_SKID -- requirements
Module: mwpipe_skid

Interface
REQ-001 Parameter SCALAR_W, default 32: scalar ALU result width.
REQ-002 Parameter LANES, default 4: vector lane count.
REQ-003 Parameter LANE_W, default 32: bits per vector lane; vector bus is VEC_W = LANES*LANE_W.
REQ-004 Parameter RADDR_W, default 4: destination register address width.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 valid_M  in  1  upstream (memory stage) payload valid.
REQ-008 ready_M  out  1  block can accept a payload this cycle.
REQ-009 regw_M, regmem_M  in  1 each  register-write and mem-to-reg controls.
REQ-010 regScr_M  in  RADDR_W  destination register.
REQ-011 ALUrslt_M  in  SCALAR_W  scalar result.
REQ-012 regVrslt_M  in  VEC_W  vector result.
REQ-013 flush  in  1  discard all held payloads.
REQ-014 valid_W  out  1  downstream (writeback) payload valid.
REQ-015 ready_W  in  1  writeback stage accepts payload.
REQ-016 regw_W, regmem_W, regScr_W, ALUrslt_W, regVrslt_W  out  widths as _M  registered payload.
REQ-017 stall_cnt  out  16  stall-cycle count (see Configuration).

Function
REQ-018 Block SHALL be a two-entry skid buffer: main register drives _W outputs, skid register holds one overflow payload.
REQ-019 States SHALL be EMPTY (no entries), ONE (main only), TWO (main+skid).
REQ-020 ready_M SHALL be 1 in EMPTY and ONE, 0 in TWO; driven from a register, no combinational path from ready_W.
REQ-021 Transfer in SHALL occur when valid_M && ready_M; transfer out when valid_W && ready_W.
REQ-022 valid_W SHALL be 1 in ONE and TWO, 0 in EMPTY.
REQ-023 EMPTY: transfer in -> ONE, payload to main, visible on _W next cycle (latency 1).
REQ-024 ONE: in without out -> TWO (payload to skid); in with out -> ONE (payload replaces main); out only -> EMPTY.
REQ-025 TWO: out -> ONE, skid payload moves to main; no out -> TWO, hold.
REQ-026 Payload order SHALL be preserved; no payload dropped or duplicated outside flush.
REQ-027 _W payload SHALL stay stable while valid_W && !ready_W.
REQ-028 flush SHALL force EMPTY next cycle, overriding any simultaneous transfer in or out; payload registers need not clear.
REQ-029 regw_W SHALL be gated: output 0 whenever valid_W is 0, so no register write occurs on bubbles.

Reset
REQ-030 On rst assertion, immediately and independent of clk: state EMPTY, valid_W 0, ready_M 1, all _W payload outputs 0, skid cleared, stall_cnt 0.
REQ-031 Reset asserted mid-transfer SHALL discard both entries; first accepted payload after release appears one cycle later.

Configuration
REQ-032 Macro MWPIPE_STALL_CNT_EN defined: stall_cnt SHALL increment each cycle valid_W && !ready_W, saturate at 16'hFFFF, clear on reset or flush.
REQ-033 Macro MWPIPE_STALL_CNT_EN undefined: stall_cnt SHALL be constant 0, no counter logic.

Verification
REQ-034 Reset then valid_M=1, regw_M=1, regScr_M=4'b0011, ALUrslt_M=32'h0000FFFF, ready_W=1 -> next cycle valid_W=1, regScr_W=4'b0011, ALUrslt_W=32'h0000FFFF.
REQ-035 ready_W=0, two payloads (regScr 3, then 4) -> ready_M=0 after second; release ready_W -> regScr_W 3 then 4, one per cycle, ready_M back to 1.
REQ-036 Continuous streaming, ready_W=1, regVrslt_M incrementing from 128'h1 -> output stream identical, one cycle delayed, no gaps.
REQ-037 TWO state plus flush=1 with valid_M=1 -> next cycle valid_W=0, regw_W=0, ready_M=1; flushed payloads never appear.
REQ-038 rst asserted between clock edges while in ONE -> valid_W and all _W outputs 0 before next edge.
REQ-039 With MWPIPE_STALL_CNT_EN, hold valid_W=1, ready_W=0 for 5 cycles -> stall_cnt=5; without macro stall_cnt=0.
